// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle control unit, immediate extender and ALU.
// Latency: none (constants, types and a pure helper function).
// Backpressure: not applicable.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // Immediate format for an opcode; unknown opcodes fall back to the I format.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode from the FSM's aluop class and the instruction funct fields.
// Latency: purely combinational.
// Backpressure: not applicable.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alucontrol_o,
  output logic       bad_funct_o
);

  // Fixed add/sub for address and compare phases; funct-decoded for execute phases.
  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) can subtract; addi ignores instr[30].
          F3_ADD:  alucontrol_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          F3_SLT:  alucontrol_o = ALU_SLT;
          F3_OR:   alucontrol_o = ALU_OR;
          F3_AND:  alucontrol_o = ALU_AND;
          default: bad_funct_o  = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: datapath selects, write enables, immsrc, alucontrol.
// Latency: Moore outputs from the state register; one instruction phase per cycle.
// Backpressure: none; the FSM advances every cycle.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e     state_q, state_d;
  state_e     out_state;
  logic [1:0] aluop;
  logic       ill_state;
  logic       bad_funct;

  // While reset is held, outputs look like FETCH even before the state register settles.
  assign out_state = reset ? S_FETCH : state_q;
  assign immsrc    = imm_sel(op);

  alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-phase outputs; write enables are squashed while reset is high.
  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    ill_state = 1'b0;
    state_d   = S_FETCH;
    case (out_state)
      S_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = SRCB_4;
        resultsrc = RES_ALURES;
        pcwrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into the ALU output register.
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_MEM;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq, inverting the zero test.
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcwrite = zero ^ funct3[0];
        state_d = S_FETCH;
      end
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_4;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        resultsrc = RES_IMM;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        ill_state = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    illegal = ill_state | bad_funct;
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
